soc_dbus_interconnect: RTL
==========================

Name: soc_dbus_interconnect

Overview:
- Parametrised data-bus interconnect between the core's data port and N memory-mapped slaves: DMEM plus future peripherals such as UART, timer and GPIO.
- Replaces the single hard-wired core-to-DMEM connection in the SoC top.
- Adds address decoding, a request/ack handshake with slave wait states, per-transaction timeout and an error response for unmapped addresses.
- Sits between rv32i_core_top's data port and the slave memories/peripherals.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- N_SLAVES, 4, number of slave ports (1..16).
- SLV_BASE, {N_SLAVES{ADDR_W'h0}}, packed base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, {N_SLAVES{ADDR_W'h0}}, packed decode masks; slave i is hit when (addr & MASK_i) == BASE_i.
- TIMEOUT, 15, maximum ACCESS cycles without ack before an error response; 0 disables the timeout.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_req  in  1  master request; sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  byte address.
- m_wdata  in  DATA_W  write data.
- m_be  in  DATA_W/8  byte enables.
- m_rdata  out  DATA_W  read data; valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag; valid while m_ready=1.
- s_req  out  N_SLAVES  one-hot slave request.
- s_we  out  1  shared write strobe.
- s_addr  out  ADDR_W  shared latched address.
- s_wdata  out  DATA_W  shared latched write data.
- s_be  out  DATA_W/8  shared latched byte enables.
- s_rdata  in  N_SLAVES*DATA_W  packed slave read data.
- s_ack  in  N_SLAVES  slave completion strobes.

Behaviour:
- Reset:
  - rst=0 forces IDLE immediately, regardless of clock.
  - All outputs go to 0 and the timeout counter clears.
  - A reset during ACCESS drops s_req with no response to the master.
- FSM states are IDLE, ACCESS, RESP, ERR.
- IDLE:
  - On a clock edge with m_req=1, latch addr, we, wdata and be.
  - Decode: the lowest-index slave that matches wins, and its index is stored in sel.
  - Hit: go to ACCESS. Miss: go to ERR.
- ACCESS:
  - s_req[sel]=1; all other s_req bits are 0.
  - s_addr, s_we, s_wdata and s_be come from the latched registers and stay stable for the whole access.
  - The counter increments every cycle.
  - s_ack[sel]=1: capture s_rdata[sel] into the read-data register (0 for writes), clear err, go to RESP.
  - TIMEOUT != 0, counter == TIMEOUT-1 and no ack: read-data = 0, err = 1, go to RESP.
  - If ack arrives in the same cycle the timeout fires, ack wins.
  - s_ack from non-selected slaves is ignored at all times.
- RESP: m_ready=1 and m_rdata/m_err are driven for exactly one cycle, then IDLE.
- ERR: m_ready=1, m_err=1, m_rdata=0 for one cycle, then IDLE. No s_req is issued.
- Outside RESP/ERR: m_ready=0, m_err=0, m_rdata=0.
- Latency:
  - Request sampled at edge N, zero-wait slave (ack in the first ACCESS cycle): m_ready high in cycle N+2.
  - Each wait state adds one cycle.
  - Unmapped address: m_ready in cycle N+1.
- Master-side rules:
  - m_req and m_addr changing or deasserting after acceptance is ignored; the latched transaction completes.
  - m_req held high through RESP starts a new transaction only on the first IDLE edge after RESP, so back-to-back throughput is 3 cycles per access.
- The counter is $clog2(TIMEOUT+1) bits, clears on entry to ACCESS and never wraps (bounded by TIMEOUT).
- s_req is driven from flops only; there is no combinational path from m_* to s_*.

Test Plan:
- BASE0=0x0000_0000/MASK0=0xFFFF_F000, BASE1=0x1000_0000/MASK1=0xFFFF_F000. Write 0xDEADBEEF, be=4'hF, to 0x10 with slave0 acking in its first ACCESS cycle -> s_req=4'b0001 for 1 cycle, s_addr=0x10; m_ready 2 cycles after the request, m_err=0.
- Read 0x1000_0004, slave1 asserts ack after 3 wait cycles with s_rdata=0x12345678 -> s_req[1] high 4 cycles; m_ready=1 with m_rdata=0x12345678 and m_err=0.
- Read 0x8000_0000 (unmapped) -> no s_req bit ever rises; next cycle m_ready=1, m_err=1, m_rdata=0.
- TIMEOUT=15, slave0 never acks -> s_req[0] high exactly 15 cycles, then m_ready=1, m_err=1, m_rdata=0.
- Same as above but ack arrives on the 15th cycle with s_rdata=0xA5A5A5A5 -> m_err=0 and m_rdata=0xA5A5A5A5.
- Pull rst low during the 2nd ACCESS cycle -> s_req=0 and m_ready=0 asynchronously; after release, a new request completes normally.

Source files
------------

// File: rtl/soc_dbus_interconnect.sv
// ----------------------------------------------------------------------------
// soc_dbus_interconnect
//   Data-bus interconnect between the core data port and N_SLAVES
//   memory-mapped slaves. It latches a master request, decodes the address
//   against per-slave base/mask pairs (the lowest matching index wins) and
//   issues a one-hot request to the selected slave. It then waits for that
//   slave's ack, bounded by TIMEOUT cycles. The master sees a single-cycle
//   m_ready pulse carrying read data and an error flag. An unmapped address
//   is answered with an error and no slave request is issued.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   m_req    : master request, sampled only while idle
//   m_we     : 1 = write, 0 = read
//   m_addr   : byte address
//   m_wdata  : write data
//   m_be     : byte enables
//   m_rdata  : read data, valid with m_ready (0 otherwise)
//   m_ready  : one-cycle completion pulse
//   m_err    : error flag, valid with m_ready (0 otherwise)
//   s_req    : one-hot slave request (registered)
//   s_we     : shared latched write strobe
//   s_addr   : shared latched address
//   s_wdata  : shared latched write data
//   s_be     : shared latched byte enables
//   s_rdata  : packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_ack    : slave completion strobes
// ----------------------------------------------------------------------------
module soc_dbus_interconnect #(
  parameter int                           ADDR_W   = 32,
  parameter int                           DATA_W   = 32,
  parameter int                           N_SLAVES = 4,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_MASK = '0,
  parameter int                           TIMEOUT  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_be,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic                         m_err,
  output logic [N_SLAVES-1:0]          s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_be,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_ack
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Counter value seen in the last ACCESS cycle before the timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic             TO_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]          state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [BE_W-1:0]     be_r;
  logic [SEL_W-1:0]    sel_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [N_SLAVES-1:0] s_req_r;
  logic                m_ready_r;
  logic                m_err_r;
  logic [DATA_W-1:0]   m_rdata_r;

  logic [N_SLAVES-1:0] match_s;
  logic                hit_s;
  logic [SEL_W-1:0]    hit_idx_s;
  logic                ack_s;
  logic [DATA_W-1:0]   sel_rdata_s;
  logic                timeout_s;

  // Priority encoder: lowest set index wins (scan from the top down).
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_SLAVES-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = SEL_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Index to one-hot slave request vector.
  function automatic logic [N_SLAVES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SLAVES-1:0] r;
    r = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      r[i] = (idx == SEL_W'(i));
    end
    return r;
  endfunction

  // Address decode of the live master address against every base/mask pair.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      match_s[i] = ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
    end
    hit_s     = |match_s;
    hit_idx_s = lowest_idx(match_s);
  end

  // Select ack and read data of the latched slave only; other acks are ignored.
  always_comb begin
    ack_s       = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      ack_s       = ack_s | (s_ack[i] & (sel_r == SEL_W'(i)));
      sel_rdata_s = sel_rdata_s | ({DATA_W{sel_r == SEL_W'(i)}} & s_rdata[i*DATA_W +: DATA_W]);
    end
    timeout_s = TO_EN & (cnt_r == CNT_LAST);
  end

  // Transaction FSM with latched request and registered master/slave outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      be_r      <= '0;
      sel_r     <= '0;
      cnt_r     <= '0;
      s_req_r   <= '0;
      m_ready_r <= 1'b0;
      m_err_r   <= 1'b0;
      m_rdata_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          m_ready_r <= 1'b0;
          m_err_r   <= 1'b0;
          m_rdata_r <= '0;
          if (m_req) begin
            addr_r  <= m_addr;
            we_r    <= m_we;
            wdata_r <= m_wdata;
            be_r    <= m_be;
            sel_r   <= hit_idx_s;
            cnt_r   <= '0;
            if (hit_s) begin
              s_req_r <= onehot(hit_idx_s);
              state_r <= ST_ACCESS;
            end else begin
              // Unmapped: answer on the very next cycle, no slave touched.
              m_ready_r <= 1'b1;
              m_err_r   <= 1'b1;
              state_r   <= ST_ERR;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over a timeout firing in the same cycle.
          if (ack_s) begin
            s_req_r   <= '0;
            m_ready_r <= 1'b1;
            m_err_r   <= 1'b0;
            m_rdata_r <= we_r ? '0 : sel_rdata_s;
            state_r   <= ST_RESP;
          end else if (timeout_s) begin
            s_req_r   <= '0;
            m_ready_r <= 1'b1;
            m_err_r   <= 1'b1;
            m_rdata_r <= '0;
            state_r   <= ST_RESP;
          end else begin
            // Saturate so a disabled timeout never lets the counter wrap.
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else begin
              cnt_r <= cnt_r;
            end
            state_r <= ST_ACCESS;
          end
        end
        ST_RESP, ST_ERR: begin
          m_ready_r <= 1'b0;
          m_err_r   <= 1'b0;
          m_rdata_r <= '0;
          state_r   <= ST_IDLE;
        end
        default: begin
          s_req_r   <= '0;
          m_ready_r <= 1'b0;
          m_err_r   <= 1'b0;
          m_rdata_r <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_req   = s_req_r;
  assign s_we    = we_r;
  assign s_addr  = addr_r;
  assign s_wdata = wdata_r;
  assign s_be    = be_r;
  assign m_ready = m_ready_r;
  assign m_err   = m_err_r;
  assign m_rdata = m_rdata_r;

endmodule
